// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and helpers for the register-bank slice.
//   axi4l_resp_t : 2-bit response code, RESP_OKAY / RESP_SLVERR
//   wr_state_t   : write-channel FSM states
//   rd_state_t   : read-channel FSM states
//   apply_wstrb  : byte-lane merge of a new word into an old word (up to 64 bits)
package axi4l_pkg;

    typedef logic [1:0] axi4l_resp_t;

    localparam axi4l_resp_t RESP_OKAY   = 2'b00;
    localparam axi4l_resp_t RESP_SLVERR = 2'b10;

    // Widest data bus the merge helper handles; narrower buses are zero-extended.
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // Byte k of the result comes from new_word when strb[k] is set, else from old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] apply_wstrb(
        input logic [MAX_DATA_WIDTH-1:0]   old_word,
        input logic [MAX_DATA_WIDTH-1:0]   new_word,
        input logic [MAX_DATA_WIDTH/8-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        for (int k = 0; k < MAX_DATA_WIDTH/8; k++) begin
            merged[k*8 +: 8] = strb[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4l_ctrl_regs.sv
// AXI4-Lite slave register bank.
//   axi4l_aclk / axi4l_arstn : clock, synchronous active-low reset
//   s_aw* / s_w* / s_b*      : write address, write data, write response channels
//   s_ar* / s_r*             : read address and read data channels
//   ctrl_out                 : contents of all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   status_in                : sources for read-only registers (RO_MASK bits)
//   wr_pulse / rd_pulse      : one-cycle strobe per successful write / read of register i
// All ready/valid outputs are registered, so no input reaches them combinationally.
module axi4l_ctrl_regs
    import axi4l_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           axi4l_aclk,
    input  logic                           axi4l_arstn,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                     s_awprot,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output axi4l_resp_t                    s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                     s_arprot,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output axi4l_resp_t                    s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam int TOP_LSB    = LSB + IDX_W;

    logic [DATA_WIDTH-1:0] regs        [NUM_REGS];
    logic [DATA_WIDTH-1:0] status_lane [NUM_REGS];

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s_awprot, s_arprot, s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};

    wr_state_t             wr_state, wr_state_n;
    logic                  aw_held, aw_held_n, w_held, w_held_n;
    logic [IDX_W-1:0]      aw_idx, aw_idx_n, aw_dec_idx, cur_idx;
    logic                  aw_err, aw_err_n, aw_dec_err, cur_err;
    logic [DATA_WIDTH-1:0] w_data, w_data_n, cur_data, wr_word;
    logic [STRB_WIDTH-1:0] w_strb, w_strb_n, cur_strb;
    logic                  awready_n, wready_n, bvalid_n, aw_fire, w_fire, wr_en;
    axi4l_resp_t           bresp_n;
    logic [NUM_REGS-1:0]   wr_pulse_n;

    rd_state_t             rd_state, rd_state_n;
    logic [IDX_W-1:0]      ar_dec_idx;
    logic                  ar_oor, arready_n, rvalid_n, ar_fire;
    logic [DATA_WIDTH-1:0] rdata_n;
    axi4l_resp_t           rresp_n;
    logic [NUM_REGS-1:0]   rd_pulse_n;

    // Flatten the register array onto ctrl_out and slice status_in into lanes.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
            status_lane[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Write-side decode; a write to a read-only register is refused like an out-of-range one.
    always_comb begin
        aw_dec_idx = s_awaddr[LSB +: IDX_W];
        aw_dec_err = (|s_awaddr[ADDR_WIDTH-1:TOP_LSB]) | RO_MASK[aw_dec_idx];
    end

    // Write FSM next state: AW and W are captured independently; the write commits on the
    // cycle the second of them arrives, taking held values or live bus values as appropriate.
    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_idx_n   = aw_idx;
        aw_err_n   = aw_err;
        w_data_n   = w_data;
        w_strb_n   = w_strb;
        awready_n  = s_awready;
        wready_n   = s_wready;
        bvalid_n   = s_bvalid;
        bresp_n    = s_bresp;
        wr_pulse_n = '0;
        wr_en      = 1'b0;
        aw_fire    = s_awvalid & s_awready;
        w_fire     = s_wvalid & s_wready;
        cur_idx    = aw_held ? aw_idx : aw_dec_idx;
        cur_err    = aw_held ? aw_err : aw_dec_err;
        cur_data   = w_held ? w_data : s_wdata;
        cur_strb   = w_held ? w_strb : s_wstrb;
        case (wr_state)
            WR_IDLE: begin
                if (aw_fire) begin
                    aw_held_n = 1'b1;
                    aw_idx_n  = aw_dec_idx;
                    aw_err_n  = aw_dec_err;
                end
                if (w_fire) begin
                    w_held_n = 1'b1;
                    w_data_n = s_wdata;
                    w_strb_n = s_wstrb;
                end
                if ((aw_held | aw_fire) && (w_held | w_fire)) begin
                    wr_state_n = WR_RESP;
                    bvalid_n   = 1'b1;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    if (cur_err) begin
                        bresp_n = RESP_SLVERR;
                    end else begin
                        bresp_n             = RESP_OKAY;
                        wr_en               = 1'b1;
                        wr_pulse_n[cur_idx] = 1'b1;
                    end
                end else begin
                    awready_n = !(aw_held | aw_fire);
                    wready_n  = !(w_held | w_fire);
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    wr_state_n = WR_IDLE;
                    bvalid_n   = 1'b0;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
        wr_word = DATA_WIDTH'(apply_wstrb(MAX_DATA_WIDTH'(regs[cur_idx]),
                                          MAX_DATA_WIDTH'(cur_data),
                                          (MAX_DATA_WIDTH/8)'(cur_strb)));
    end

    // Write FSM state and write-channel output registers.
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            wr_state  <= WR_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx    <= '0;
            aw_err    <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            wr_pulse  <= '0;
        end else begin
            wr_state  <= wr_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            aw_idx    <= aw_idx_n;
            aw_err    <= aw_err_n;
            w_data    <= w_data_n;
            w_strb    <= w_strb_n;
            s_awready <= awready_n;
            s_wready  <= wready_n;
            s_bvalid  <= bvalid_n;
            s_bresp   <= bresp_n;
            wr_pulse  <= wr_pulse_n;
        end
    end

    // Register array; only an accepted, in-range, writable commit changes it.
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[cur_idx] <= wr_word;
        end
    end

    // Read FSM next state: the read samples the array before this edge's write commit lands,
    // so a same-edge write to the same register returns the old value.
    always_comb begin
        rd_state_n = rd_state;
        arready_n  = s_arready;
        rvalid_n   = s_rvalid;
        rdata_n    = s_rdata;
        rresp_n    = s_rresp;
        rd_pulse_n = '0;
        ar_fire    = s_arvalid & s_arready;
        ar_dec_idx = s_araddr[LSB +: IDX_W];
        ar_oor     = |s_araddr[ADDR_WIDTH-1:TOP_LSB];
        case (rd_state)
            RD_IDLE: begin
                if (ar_fire) begin
                    rd_state_n = RD_RESP;
                    arready_n  = 1'b0;
                    rvalid_n   = 1'b1;
                    if (ar_oor) begin
                        rdata_n = '0;
                        rresp_n = RESP_SLVERR;
                    end else begin
                        rdata_n                = RO_MASK[ar_dec_idx] ? status_lane[ar_dec_idx]
                                                                     : regs[ar_dec_idx];
                        rresp_n                = RESP_OKAY;
                        rd_pulse_n[ar_dec_idx] = 1'b1;
                    end
                end else begin
                    arready_n = 1'b1;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    rd_state_n = RD_IDLE;
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    // Read FSM state and read-channel output registers.
    always_ff @(posedge axi4l_aclk) begin
        if (!axi4l_arstn) begin
            rd_state  <= RD_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            rd_pulse  <= '0;
        end else begin
            rd_state  <= rd_state_n;
            s_arready <= arready_n;
            s_rvalid  <= rvalid_n;
            s_rdata   <= rdata_n;
            s_rresp   <= rresp_n;
            rd_pulse  <= rd_pulse_n;
        end
    end

endmodule

// File: tb/tb_axi4l_ctrl_regs.sv
// Self-checking bench for axi4l_ctrl_regs (16 x 32-bit registers, register 3 read-only).
// Expected responses are queued when a transaction is driven and checked by a monitor
// as the B and R channels present them.
module tb_axi4l_ctrl_regs;
    import axi4l_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0008;

    logic              clk = 1'b0;
    logic              arstn;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [2:0]        s_awprot, s_arprot;
    logic              s_awvalid, s_awready, s_wvalid, s_wready;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [DW/8-1:0]   s_wstrb;
    axi4l_resp_t       s_bresp, s_rresp;
    logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NR*DW-1:0]  ctrl_out, status_in;
    logic [NR-1:0]     wr_pulse, rd_pulse;

    always #5 clk = ~clk;

    axi4l_ctrl_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .axi4l_aclk(clk), .axi4l_arstn(arstn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [15:0] exp_pulse;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [15:0] pulse;
    } exp_t;

    exp_t qB[$];
    exp_t qR[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic prev_b = 1'b0;
    logic prev_r = 1'b0;
    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out, got no handshake, expected one at %0t", name, $time);
    endtask

    // Monitor: pulses must match the queued expectation on the first valid cycle and be
    // zero otherwise; response fields are checked every valid cycle to catch instability.
    always @(negedge clk) begin
        if (s_bvalid) begin
            if (qB.size() == 0) begin
                timeoutFail("b_unexpected");
            end else begin
                checkOutput("bresp", s_bresp, qB[0].resp);
                checkOutput("wr_pulse", wr_pulse, prev_b ? 16'h0 : qB[0].pulse);
                if (s_bready) void'(qB.pop_front());
            end
        end else begin
            checkOutput("wr_pulse_idle", wr_pulse, 16'h0);
        end
        prev_b = s_bvalid && !s_bready;
        if (s_rvalid) begin
            if (qR.size() == 0) begin
                timeoutFail("r_unexpected");
            end else begin
                checkOutput("rdata", s_rdata, qR[0].data);
                checkOutput("rresp", s_rresp, qR[0].resp);
                checkOutput("rd_pulse", rd_pulse, prev_r ? 16'h0 : qR[0].pulse);
                if (s_rready) void'(qR.pop_front());
            end
        end else begin
            checkOutput("rd_pulse_idle", rd_pulse, 16'h0);
        end
        prev_r = s_rvalid && !s_rready;
    end

    // Each driver starts at posedge+1 and returns at posedge+1 after its handshake edge.
    task automatic driveAw(input logic [31:0] a);
        s_awaddr  = a;
        s_awvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (s_awready) begin
                @(posedge clk); #1;
                s_awvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_awvalid = 1'b0;
        timeoutFail("aw_handshake");
    endtask

    task automatic driveW(input logic [31:0] d, input logic [3:0] s);
        s_wdata  = d;
        s_wstrb  = s;
        s_wvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (s_wready) begin
                @(posedge clk); #1;
                s_wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_wvalid = 1'b0;
        timeoutFail("w_handshake");
    endtask

    task automatic driveAr(input logic [31:0] a);
        s_araddr  = a;
        s_arvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (s_arready) begin
                @(posedge clk); #1;
                s_arvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        timeoutFail("ar_handshake");
    endtask

    task automatic pushB(input logic [1:0] resp, input logic [15:0] pulse);
        exp_t e;
        e.data  = 32'h0;
        e.resp  = resp;
        e.pulse = pulse;
        qB.push_back(e);
    endtask

    task automatic pushR(input logic [31:0] data, input logic [1:0] resp, input logic [15:0] pulse);
        exp_t e;
        e.data  = data;
        e.resp  = resp;
        e.pulse = pulse;
        qR.push_back(e);
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input logic [15:0] pulse);
        pushB(resp, pulse);
        fork
            driveAw(a);
            driveW(d, s);
        join
    endtask

    task automatic doRead(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] resp, input logic [15:0] pulse);
        pushR(d, resp, pulse);
        driveAr(a);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 200; n++) begin
            if (qB.size() == 0 && qR.size() == 0) return;
            @(posedge clk); #1;
        end
        timeoutFail("response_drain");
        qB.delete();
        qR.delete();
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_wr) doWrite(v.addr, v.data, v.strb, v.exp_resp, v.exp_pulse);
        else         doRead(v.addr, v.exp_data, v.exp_resp, v.exp_pulse);
        waitDrain();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        RESP_OKAY,   16'h0002};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY,   16'h0002};
        vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        RESP_OKAY,   16'h0004};
        vecs[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        RESP_OKAY,   16'h0004};
        vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, RESP_OKAY,   16'h0004};
        vecs[5]  = '{1'b1, 32'h0C, 32'h1,        4'hF, 32'h0,        RESP_SLVERR, 16'h0000};
        vecs[6]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0000CAFE, RESP_OKAY,   16'h0008};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        RESP_SLVERR, 16'h0000};
        vecs[8]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        RESP_SLVERR, 16'h0000};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        RESP_OKAY,   16'h0001};
        vecs[10] = '{1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 32'h0,        RESP_OKAY,   16'h0020};
        vecs[11] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h0,        RESP_OKAY,   16'h0020};
        vecs[12] = '{1'b0, 32'h06, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY,   16'h0002};
        vecs[13] = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'hC, 32'h0,        RESP_OKAY,   16'h8000};
        vecs[14] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'hA5A50000, RESP_OKAY,   16'h8000};

        arstn     = 1'b0;
        s_awaddr  = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb  = '0; s_wvalid  = 1'b0;
        s_araddr  = '0; s_arprot = '0; s_arvalid = 1'b0;
        s_bready  = 1'b1;
        s_rready  = 1'b1;
        status_in = '0;
        status_in[3*DW +: DW] = 32'h0000CAFE;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_awready", s_awready, 1'b0);
        checkOutput("reset_wready", s_wready, 1'b0);
        checkOutput("reset_arready", s_arready, 1'b0);
        checkOutput("reset_bvalid", s_bvalid, 1'b0);
        checkOutput("reset_rvalid", s_rvalid, 1'b0);
        checkOutput("reset_ctrl_zero", ctrl_out == '0, 1'b1);
        arstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_awready", s_awready, 1'b1);
        checkOutput("release_wready", s_wready, 1'b1);
        checkOutput("release_arready", s_arready, 1'b1);

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
        checkOutput("ctrl_lane1", ctrl_out[1*DW +: DW], 32'hDEADBEEF);
        checkOutput("ctrl_lane2", ctrl_out[2*DW +: DW], 32'h11BB33DD);
        checkOutput("ctrl_lane3_ro", ctrl_out[3*DW +: DW], 32'h0);
        checkOutput("ctrl_lane0", ctrl_out[0*DW +: DW], 32'h0);

        $display("[TB] W before AW with stalled B");
        s_bready = 1'b0;
        pushB(RESP_OKAY, 16'h0040);
        driveW(32'h600DF00D, 4'hF);
        checkOutput("w_held_wready", s_wready, 1'b0);
        checkOutput("w_held_awready", s_awready, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        driveAw(32'h18);
        for (int n = 0; n < 4; n++) begin
            checkOutput("stall_bvalid", s_bvalid, 1'b1);
            checkOutput("stall_awready", s_awready, 1'b0);
            checkOutput("stall_wready", s_wready, 1'b0);
            @(posedge clk); #1;
        end
        s_bready = 1'b1;
        waitDrain();
        checkOutput("ctrl_lane6", ctrl_out[6*DW +: DW], 32'h600DF00D);

        $display("[TB] AW before W with stalled B");
        s_bready = 1'b0;
        pushB(RESP_OKAY, 16'h0080);
        driveAw(32'h1C);
        checkOutput("aw_held_awready", s_awready, 1'b0);
        checkOutput("aw_held_wready", s_wready, 1'b1);
        repeat (1) begin @(posedge clk); #1; end
        driveW(32'h0BADCAFE, 4'hF);
        for (int n = 0; n < 4; n++) begin
            checkOutput("stall2_bvalid", s_bvalid, 1'b1);
            checkOutput("stall2_awready", s_awready, 1'b0);
            checkOutput("stall2_wready", s_wready, 1'b0);
            @(posedge clk); #1;
        end
        s_bready = 1'b1;
        waitDrain();
        checkOutput("ctrl_lane7", ctrl_out[7*DW +: DW], 32'h0BADCAFE);

        $display("[TB] read and write on the same edge");
        doWrite(32'h08, 32'h7, 4'hF, RESP_OKAY, 16'h0004);
        waitDrain();
        fork
            doWrite(32'h08, 32'h5, 4'hF, RESP_OKAY, 16'h0004);
            doRead(32'h08, 32'h7, RESP_OKAY, 16'h0004);
        join
        waitDrain();
        doRead(32'h08, 32'h5, RESP_OKAY, 16'h0004);
        waitDrain();

        $display("[TB] reset with responses pending");
        s_bready = 1'b0;
        s_rready = 1'b0;
        pushB(RESP_OKAY, 16'h0010);
        pushR(32'hDEADBEEF, RESP_OKAY, 16'h0002);
        fork
            driveAw(32'h10);
            driveW(32'h44, 4'hF);
            driveAr(32'h04);
        join
        checkOutput("pending_bvalid", s_bvalid, 1'b1);
        checkOutput("pending_rvalid", s_rvalid, 1'b1);
        arstn = 1'b0;
        @(posedge clk); #1;
        qB.delete();
        qR.delete();
        checkOutput("rst_bvalid", s_bvalid, 1'b0);
        checkOutput("rst_rvalid", s_rvalid, 1'b0);
        checkOutput("rst_rdata", s_rdata, 32'h0);
        checkOutput("rst_awready", s_awready, 1'b0);
        checkOutput("rst_ctrl_zero", ctrl_out == '0, 1'b1);
        arstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("rerelease_awready", s_awready, 1'b1);
        checkOutput("rerelease_wready", s_wready, 1'b1);
        checkOutput("rerelease_arready", s_arready, 1'b1);
        s_bready = 1'b1;
        s_rready = 1'b1;
        doWrite(32'h10, 32'h99, 4'hF, RESP_OKAY, 16'h0010);
        waitDrain();
        doRead(32'h10, 32'h99, RESP_OKAY, 16'h0010);
        waitDrain();
        checkOutput("ctrl_lane4", ctrl_out[4*DW +: DW], 32'h99);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi4l_ctrl_regs.md
Name: axi4l_ctrl_regs

Overview:
Synthesizable AXI4-Lite responder (slave) register bank, and the counterpart to the team's AXI4-Lite master BFM.
- Exposes NUM_REGS word registers to a bus master.
- Writable registers drive fabric control outputs; read-only registers reflect fabric status inputs.
- Byte strobes, address-range checking and per-register access pulses are supported.
- Single outstanding transaction per direction; the read and write paths are independent.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64)
NUM_REGS, 16, number of registers (power of 2, >= 2)
RO_MASK, '0 (NUM_REGS bits), bit i = 1 makes register i read-only, sourced from status_in

Ports:
axi4l_aclk  in  1  clock
axi4l_arstn  in  1  synchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awprot  in  3  ignored
s_awvalid  in  1 / s_awready  out  1  AW handshake
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte strobes
s_wvalid  in  1 / s_wready  out  1  W handshake
s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  B channel
s_araddr  in  ADDR_WIDTH  read address
s_arprot  in  3  ignored
s_arvalid  in  1 / s_arready  out  1  AR handshake
s_rdata  out  DATA_WIDTH / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1  R channel
ctrl_out  out  NUM_REGS*DATA_WIDTH  writable register contents; register i occupies [i*DATA_WIDTH +: DATA_WIDTH]
status_in  in  NUM_REGS*DATA_WIDTH  read-only register sources (lanes of writable registers unused)
wr_pulse  out  NUM_REGS  one-cycle strobe per successful write
rd_pulse  out  NUM_REGS  one-cycle strobe per successful read

Behaviour:
Reset (axi4l_arstn = 0 at a clock edge):
- All outputs 0: readies, valids, resps, rdata, ctrl_out, pulses.
- Any in-flight transaction is discarded.
- awready, wready and arready go to 1 on the first edge with reset released.

Decode:
- LSB = log2(DATA_WIDTH/8); idx = addr[LSB +: log2(NUM_REGS)]. Bits below LSB are ignored.
- Any addr bit above the idx field nonzero -> out of range.

Write FSM, states WR_IDLE and WR_RESP:
- WR_IDLE: awready = !aw_held, wready = !w_held. AW and W are accepted independently, in either order or the same cycle, and held.
- At the edge where the second of AW/W completes: commit the write, go to WR_RESP, assert bvalid. awready/wready drop to 0.
- Commit: byte lane k of register idx is updated only if wstrb[k]. wr_pulse[idx] = 1 for exactly the first bvalid cycle. wstrb = 0 is still OKAY and still pulses.
- Error: out-of-range or RO idx -> no update, no pulse, bresp = SLVERR (2'b10). Otherwise bresp = OKAY (2'b00).
- WR_RESP: bvalid held, bresp stable until bready. On the bvalid & bready edge -> WR_IDLE, clear held flags, readies = 1 next cycle.
- Minimum write spacing is 2 cycles.

Read FSM, states RD_IDLE and RD_RESP:
- RD_IDLE: arready = 1. The AR handshake at edge m samples register contents as they stand before edge m. rdata, rresp and rvalid are registered at edge m.
- RO register -> status_in lane. RW register -> ctrl_out lane.
- Out of range -> rdata = 0, rresp = SLVERR, no pulse.
- rd_pulse[idx] = 1 for exactly the first rvalid cycle.
- RD_RESP: arready = 0; rdata/rresp/rvalid stable until rready. On the handshake edge -> RD_IDLE.

Simultaneous events:
- A read sampled on the same edge as a write commit to the same register returns the old value.
- Read and write paths never stall each other.

No combinational path from any valid/ready input to any ready/valid output.

Decomposition:
- axi4l_pkg gains typedef axi4l_resp_t (2-bit) and constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
- axi4l_pkg gains function apply_wstrb(old, new, strb) returning the byte-merged word.
- Single module, no sub-module: the two FSMs are small and share only the register array.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x04 with wstrb 0xF, then read 0x04 -> bresp 00, rdata 0xDEADBEEF, ctrl_out[63:32] = 0xDEADBEEF, wr_pulse[1] and rd_pulse[1] each high one cycle.
2. Reg 2 = 0x11223344; write 0xAABBCCDD with wstrb 0x5 -> reg 2 = 0x11BB33DD.
3. W presented 3 cycles before AW, then AW 2 cycles before W, bready held low 4 cycles -> both commit once; bvalid/bresp stable; awready/wready stay 0 until the B handshake.
4. RO_MASK bit 3 set, status_in lane 3 = 0x0000CAFE: write 0x1 to 0x0C -> SLVERR, no wr_pulse; read 0x0C -> 0x0000CAFE, OKAY. Read 0x40 (NUM_REGS = 16) -> SLVERR, rdata 0.
5. AR to 0x08 on the same edge that a write of 0x5 to 0x08 commits (old value 0x7) -> rdata 0x7; the next read -> 0x5.
6. Assert reset while bvalid is pending and rready is low -> next cycle all valids 0, ctrl_out 0; after release, readies 1 and a fresh write completes normally.
